// File: rtl/ddr_fill_engine_if.sv
// AXI4 write-channel subset (AW/W/B) driven by ddr_fill_engine toward ddr_sdram_ctrl.
interface ddr_fill_engine_if #(
  parameter int unsigned A_WIDTH = 25,
  parameter int unsigned D_WIDTH = 16
);
  logic               awvalid;
  logic               awready;
  logic [A_WIDTH-1:0] awaddr;
  logic [7:0]         awlen;
  logic               wvalid;
  logic               wready;
  logic               wlast;
  logic [D_WIDTH-1:0] wdata;
  logic               bvalid;
  logic               bready;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/ddr_fill_engine.sv
// Fills a contiguous DDR region with a pattern via back-to-back AXI4 write bursts.
// Define FILL_ADDR_PATTERN_EN to XOR the global beat index into each data beat.
module ddr_fill_engine #(
  parameter int unsigned A_WIDTH   = 25,
  parameter int unsigned D_WIDTH   = 16,
  parameter logic [7:0]  BURST_LEN = 8'd7,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [A_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0] burst_cnt,
  input  logic [D_WIDTH-1:0]   pattern,
  output logic                 busy,
  output logic                 done,
  ddr_fill_engine_if.master    axi
);

  localparam int unsigned StepInt = (32'(BURST_LEN) + 32'd1) * (D_WIDTH / 8);
  localparam logic [A_WIDTH-1:0] Step = A_WIDTH'(StepInt);

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [D_WIDTH-1:0]   pattern_q, pattern_d;
  logic [7:0]           beat_q, beat_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 wlast_q, wlast_d;
  logic [D_WIDTH-1:0]   wdata_q, wdata_d;
  logic                 bready_q, bready_d;
`ifdef FILL_ADDR_PATTERN_EN
  logic [D_WIDTH-1:0]   gbeat_q, gbeat_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    beat_d    = beat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    wdata_d   = wdata_q;
    bready_d  = bready_q;
`ifdef FILL_ADDR_PATTERN_EN
    gbeat_d   = gbeat_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d     = burst_cnt;
          pattern_d = pattern;
`ifdef FILL_ADDR_PATTERN_EN
          gbeat_d   = '0;
`endif
          if (burst_cnt != '0) begin
            state_d   = StAw;
            addr_d    = base_addr;
            busy_d    = 1'b1;
            awvalid_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StAw: begin
        if (axi.awready) begin
          state_d   = StW;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = '0;
          wlast_d   = (BURST_LEN == 8'd0);
        end
      end
      StW: begin
        if (axi.wready) begin
          beat_d = beat_q + 8'd1;
`ifdef FILL_ADDR_PATTERN_EN
          gbeat_d = gbeat_q + 1'b1;
`endif
          if (wlast_q) begin
            state_d  = StB;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            wlast_d = (beat_q + 8'd1 == BURST_LEN);
          end
        end
      end
      StB: begin
        if (axi.bvalid) begin
          bready_d = 1'b0;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = StAw;
            addr_d    = addr_q + Step;
            awvalid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Data for the beat presented next; only changes on entering W or after a W handshake.
    if ((state_q == StAw && axi.awready) || (state_q == StW && axi.wready && !wlast_q)) begin
`ifdef FILL_ADDR_PATTERN_EN
      wdata_d = pattern_q ^ gbeat_d;
`else
      wdata_d = pattern_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      pattern_q <= '0;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      wdata_q   <= '0;
      bready_q  <= 1'b0;
`ifdef FILL_ADDR_PATTERN_EN
      gbeat_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      beat_q    <= beat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      wdata_q   <= wdata_d;
      bready_q  <= bready_d;
`ifdef FILL_ADDR_PATTERN_EN
      gbeat_q   <= gbeat_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = BURST_LEN;
  assign axi.wvalid  = wvalid_q;
  assign axi.wlast   = wlast_q;
  assign axi.wdata   = wdata_q;
  assign axi.bready  = bready_q;

endmodule
